// File: rtl/color_quantizer.sv
// Maps an RGB888 pixel onto the 7-entry RGB333 track palette. The search is
// sequential, one entry per cycle, and the nearest entry wins by L1 distance.
module color_quantizer #(
  parameter int ALLOW_NEAREST = 1,
  parameter int DIST_W        = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] pixel_24bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  pixel_9bit,
  output logic [2:0]  pal_index,
  output logic        exact_hit
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [2:0] LAST_IDX  = 3'd6;
  localparam logic [2:0] BLACK_IDX = 3'd4;

  function automatic logic [23:0] pal_rgb(input logic [2:0] i);
    case (i)
      3'd0:    pal_rgb = 24'h006600;
      3'd1:    pal_rgb = 24'h333333;
      3'd2:    pal_rgb = 24'h663319;
      3'd3:    pal_rgb = 24'hFFFFFF;
      3'd4:    pal_rgb = 24'h000000;
      3'd5:    pal_rgb = 24'hFF0000;
      3'd6:    pal_rgb = 24'h0000FF;
      default: pal_rgb = 24'h000000;
    endcase
  endfunction

  function automatic logic [8:0] pal_code(input logic [2:0] i);
    case (i)
      3'd0:    pal_code = 9'b000_100_000;
      3'd1:    pal_code = 9'b010_010_010;
      3'd2:    pal_code = 9'b100_010_001;
      3'd3:    pal_code = 9'b111_111_111;
      3'd4:    pal_code = 9'b000_000_000;
      3'd5:    pal_code = 9'b111_000_000;
      3'd6:    pal_code = 9'b000_000_111;
      default: pal_code = 9'b000_000_000;
    endcase
  endfunction

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    absdiff = (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [1:0]        r_state;
  logic [23:0]       r_pix;
  logic [2:0]        r_idx;
  logic [DIST_W-1:0] r_best_dist;
  logic [2:0]        r_best_idx;
  logic              r_hit;
  logic              r_out_valid;
  logic [8:0]        r_code;
  logic [2:0]        r_pidx;
  logic              r_ohit;

  logic [23:0]       w_ent;
  logic [DIST_W-1:0] w_dr, w_dg, w_db, w_d;

  assign w_ent = pal_rgb(r_idx);
  assign w_dr  = DIST_W'(absdiff(r_pix[23:16], w_ent[23:16]));
  assign w_dg  = DIST_W'(absdiff(r_pix[15:8],  w_ent[15:8]));
  assign w_db  = DIST_W'(absdiff(r_pix[7:0],   w_ent[7:0]));
  assign w_d   = w_dr + w_dg + w_db;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pix       <= '0;
      r_idx       <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_hit       <= 1'b0;
      r_out_valid <= 1'b0;
      r_code      <= '0;
      r_pidx      <= '0;
      r_ohit      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_pix       <= pixel_24bit;
            r_best_dist <= '1;
            r_best_idx  <= '0;
            r_idx       <= '0;
            r_hit       <= 1'b0;
            r_state     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          // strict compare keeps the lower index on ties
          if (w_d < r_best_dist) begin
            r_best_dist <= w_d;
            r_best_idx  <= r_idx;
          end
          if (w_d == '0) r_hit <= 1'b1;
          if (r_idx == LAST_IDX) r_state <= S_DONE;
          else                   r_idx   <= r_idx + 3'd1;
        end
        S_DONE: begin
          // first DONE cycle registers the result; then hold until accepted
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            if (r_hit || (ALLOW_NEAREST != 0)) begin
              r_code <= pal_code(r_best_idx);
              r_pidx <= r_best_idx;
              r_ohit <= r_hit;
            end else begin
              r_code <= 9'h000;
              r_pidx <= BLACK_IDX;
              r_ohit <= 1'b0;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign pixel_9bit = r_code;
  assign pal_index  = r_pidx;
  assign exact_hit  = r_ohit;

endmodule

// File: tb/tb_color_quantizer.sv
// Scoreboard bench: two instances (nearest / exact-only) share stimulus through
// a select; expected results come from an independent L1 nearest-palette model.
module tb_color_quantizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        in_valid, out_ready;
  logic [23:0] pixel;

  logic        rdy_a, vld_a, hit_a, rdy_b, vld_b, hit_b;
  logic [8:0]  code_a, code_b;
  logic [2:0]  idx_a, idx_b;

  logic        in_ready, out_valid, exact_hit;
  logic [8:0]  pixel_9bit;
  logic [2:0]  pal_index;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  color_quantizer #(.ALLOW_NEAREST(1), .DIST_W(10)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & ~sel), .in_ready(rdy_a), .pixel_24bit(pixel),
    .out_valid(vld_a), .out_ready(out_ready & ~sel),
    .pixel_9bit(code_a), .pal_index(idx_a), .exact_hit(hit_a));

  color_quantizer #(.ALLOW_NEAREST(0), .DIST_W(10)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid & sel), .in_ready(rdy_b), .pixel_24bit(pixel),
    .out_valid(vld_b), .out_ready(out_ready & sel),
    .pixel_9bit(code_b), .pal_index(idx_b), .exact_hit(hit_b));

  assign in_ready   = sel ? rdy_b  : rdy_a;
  assign out_valid  = sel ? vld_b  : vld_a;
  assign pixel_9bit = sel ? code_b : code_a;
  assign pal_index  = sel ? idx_b  : idx_a;
  assign exact_hit  = sel ? hit_b  : hit_a;

  typedef struct {
    logic [8:0] code;
    logic [2:0] idx;
    logic       hit;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0;

  logic [23:0] PAL_RGB [7] = '{24'h006600, 24'h333333, 24'h663319, 24'hFFFFFF,
                               24'h000000, 24'hFF0000, 24'h0000FF};
  logic [8:0]  PAL_CODE[7] = '{9'o040, 9'o222, 9'o421, 9'o777, 9'o000, 9'o700, 9'o007};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int ad(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic exp_t model(input logic [23:0] p, input bit allow);
    exp_t e;
    int best, d;
    best = 1 << 20;
    e.idx = 3'd0; e.hit = 1'b0; e.acc = 0;
    for (int i = 0; i < 7; i++) begin
      d = ad(int'(p[23:16]), int'(PAL_RGB[i][23:16])) + ad(int'(p[15:8]), int'(PAL_RGB[i][15:8]))
        + ad(int'(p[7:0]), int'(PAL_RGB[i][7:0]));
      if (d < best) begin best = d; e.idx = 3'(i); end
    end
    e.hit  = (best == 0);
    e.code = PAL_CODE[e.idx];
    if (!e.hit && !allow) begin e.code = 9'h000; e.idx = 3'd4; end
    return e;
  endfunction

  task automatic send(input logic [23:0] p);
    exp_t e;
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; pixel = p;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    e = model(p, !sel);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; pixel = $urandom;   // later pixel changes must be ignored
  endtask

  // hold: cycles of backpressure; chain: present next pixel in the handshake cycle
  task automatic get_out(input int hold, input bit chain, input logic [23:0] nxt);
    exp_t e;
    int n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    if (!out_valid) begin chk("out_valid_timeout", 0, 1); return; end
    e = sb.pop_front();
    chk("latency", cyc - e.acc, 8);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_code", pixel_9bit, e.code);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("code", pixel_9bit, e.code);
    chk("idx", pal_index, e.idx);
    chk("hit", exact_hit, e.hit);
    out_ready = 1'b1;
    if (chain) begin in_valid = 1'b1; pixel = nxt; end
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
    if (chain) begin
      e = model(nxt, !sel);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0; pixel = $urandom;
    end
  endtask

  initial begin
    int quiet;
    reset = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pixel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_code", pixel_9bit, 0);
    chk("rst_idx", pal_index, 0);
    chk("rst_hit", exact_hit, 0);
    chk("rst_valid_b", vld_b, 0);

    send(24'h006600); get_out(0, 0, '0);
    send(24'h303030); get_out(0, 0, '0);
    send(24'h003300); get_out(5, 1, 24'hFFFFFF);
    get_out(0, 0, '0);

    // reset mid-search drops the pixel
    send(24'h123456);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    sb.delete();
    quiet = 1;
    repeat (12) begin @(negedge clk); if (out_valid) quiet = 0; end
    chk("midrst_no_out", quiet, 1);
    send(24'hFF0000); get_out(0, 0, '0);

    for (int i = 0; i < 7; i++) begin send(PAL_RGB[i]); get_out(0, 0, '0); end
    for (int i = 0; i < 8; i++) begin send(24'($urandom)); get_out(i % 3, 0, '0); end

    sel = 1'b1;
    send(24'h123456); get_out(0, 0, '0);
    send(24'h0000FF); get_out(0, 0, '0);
    for (int i = 0; i < 3; i++) begin send(24'($urandom)); get_out(1, 0, '0); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
